debug_trace_fifo: RTL and testbench

- Sits downstream of the pipeline processor's debug port (debug_addr / debug_word).
- Captures each debug write strobe into a small FIFO, then presents the entries one at a time on held display registers. The seven-segment and LED drivers consume these registers.
- Each entry is shown for a programmable number of cycles, or until a manual step.
- Bursts of writes from the core therefore stay visible to a human at board speed.

---
 rtl/debug_trace_fifo.sv | 197 +++++++++++++++++++
 tb/tb_debug_trace_fifo.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_fifo.sv
// Trace FIFO behind the core's debug port: captures debug writes and presents them one at a time on held display registers.
// Build option: define DEBUG_TRACE_DEDUP_EN to discard captures identical to the most recently accepted entry.
module debug_trace_fifo #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic              inclock,
    input  logic              resetn,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] debug_addr,
    input  logic [DATA_W-1:0] debug_word,
    input  logic              step,
    input  logic              freeze,
    input  logic              clr_ovf,
    output logic              disp_valid,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_word,
    output logic [AW:0]       fifo_count,
    output logic              overflow,
    output logic [7:0]        drop_count
);
    // state | meaning
    // IDLE  | nothing shown since reset
    // LOAD  | pop the head entry into the display registers
    // SHOW  | hold the displayed entry until timeout or manual step
    localparam int EW = ADDR_W + DATA_W;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SHOW = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [HW-1:0]     r_hold;
    logic              r_step_d;
    logic              r_disp_valid;
    logic [ADDR_W-1:0] r_disp_addr;
    logic [DATA_W-1:0] r_disp_word;
    logic              r_overflow;
    logic [7:0]        r_drop_count;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_dup;
    logic          w_push;
    logic          w_drop;
    logic          w_step_rise;
    logic          w_advance;
    logic          w_load;
    logic          w_hold_clr;
    logic          w_hold_inc;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    assign w_entry     = {debug_addr, debug_word};
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop       = (r_state == S_LOAD);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign w_push      = dbg_we && !w_dup && (!w_full || w_pop);
    assign w_drop      = dbg_we && !w_dup && w_full && !w_pop;
    assign w_step_rise = step && !r_step_d;
    assign w_advance   = (r_hold == HOLD_LAST) || (w_step_rise && !freeze);

`ifdef DEBUG_TRACE_DEDUP_EN
    logic [EW-1:0] r_last;
    logic          r_last_vld;

    assign w_dup = r_last_vld && (w_entry == r_last);

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_push) begin
            r_last     <= w_entry;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHOW;
            S_SHOW:  if (w_advance && !w_empty) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_hold_clr = 1'b0;
        w_hold_inc = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_load     = 1'b1;
                w_hold_clr = 1'b1;
            end
            S_SHOW: begin
                w_hold_clr = w_advance;
                w_hold_inc = !w_advance && !freeze;
            end
            default: ;
        endcase
    end

    always_ff @(posedge inclock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_hold   <= '0;
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= step;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (w_hold_clr) begin
                r_hold <= '0;
            end else if (w_hold_inc) begin
                r_hold <= r_hold + HW'(1);
            end
        end
    end

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            r_disp_valid <= 1'b0;
            r_disp_addr  <= '0;
            r_disp_word  <= '0;
        end else if (w_load) begin
            r_disp_valid <= 1'b1;
            r_disp_addr  <= w_head[EW-1:DATA_W];
            r_disp_word  <= w_head[DATA_W-1:0];
        end
    end

    // A drop in the same cycle as a clear wins, restarting the count at one.
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_ovf) begin
                r_drop_count <= 8'd1;
            end else if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end else if (clr_ovf) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign disp_valid = r_disp_valid;
    assign disp_addr  = r_disp_addr;
    assign disp_word  = r_disp_word;
    assign fifo_count = r_wr_ptr - r_rd_ptr;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_debug_trace_fifo.sv
// Scoreboard bench for debug_trace_fifo: a slow (HOLD_CYCLES=1024) and a fast (HOLD_CYCLES=4) instance share stimulus.
// The display monitor follows whichever instance mon_sel selects; it is switched only while reset is held.
module tb_debug_trace_fifo;
    logic        clk;
    logic        resetn;
    logic        dbg_we;
    logic [11:0] debug_addr;
    logic [31:0] debug_word;
    logic        step;
    logic        freeze;
    logic        clr_ovf;
    logic        mon_sel;

    logic        s_valid, f_valid;
    logic [11:0] s_addr, f_addr;
    logic [31:0] s_word, f_word;
    logic [4:0]  s_count, f_count;
    logic        s_ovf, f_ovf;
    logic [7:0]  s_drop, f_drop;

    logic        m_valid;
    logic [11:0] m_addr;
    logic [31:0] m_word;
    logic [4:0]  m_count;
    logic        m_ovf;
    logic [7:0]  m_drop;

    typedef struct {
        logic [11:0] a;
        logic [31:0] w;
        int          c;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

    debug_trace_fifo #(.HOLD_CYCLES(1024)) u_slow (
        .inclock(clk), .resetn(resetn), .dbg_we(dbg_we), .debug_addr(debug_addr),
        .debug_word(debug_word), .step(step), .freeze(freeze), .clr_ovf(clr_ovf),
        .disp_valid(s_valid), .disp_addr(s_addr), .disp_word(s_word),
        .fifo_count(s_count), .overflow(s_ovf), .drop_count(s_drop)
    );

    debug_trace_fifo #(.HOLD_CYCLES(4)) u_fast (
        .inclock(clk), .resetn(resetn), .dbg_we(dbg_we), .debug_addr(debug_addr),
        .debug_word(debug_word), .step(step), .freeze(freeze), .clr_ovf(clr_ovf),
        .disp_valid(f_valid), .disp_addr(f_addr), .disp_word(f_word),
        .fifo_count(f_count), .overflow(f_ovf), .drop_count(f_drop)
    );

    assign m_valid = mon_sel ? f_valid : s_valid;
    assign m_addr  = mon_sel ? f_addr  : s_addr;
    assign m_word  = mon_sel ? f_word  : s_word;
    assign m_count = mon_sel ? f_count : s_count;
    assign m_ovf   = mon_sel ? f_ovf   : s_ovf;
    assign m_drop  = mon_sel ? f_drop  : s_drop;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Display monitor: every new entry on the display must match the head of the expected queue.
    initial begin
        logic        p_valid;
        logic [11:0] p_addr;
        logic [31:0] p_word;
        exp_t        e;
        p_valid = 1'b0;
        p_addr  = '0;
        p_word  = '0;
        forever begin
            @(negedge clk);
            if (m_valid && (!p_valid || m_addr != p_addr || m_word != p_word)) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_display: got %h/%h at cycle %0d, required no change", m_addr, m_word, cyc);
                end else begin
                    e = q.pop_front();
                    if (m_addr !== e.a || m_word !== e.w || (e.c >= 0 && cyc != e.c)) begin
                        n_err++;
                        $display("FAIL display_entry: got %h/%h at cycle %0d, required %h/%h at cycle %0d",
                                 m_addr, m_word, cyc, e.a, e.w, e.c);
                    end
                end
            end
            p_valid = m_valid;
            p_addr  = m_addr;
            p_word  = m_word;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [11:0] a, input logic [31:0] w, input int c);
        exp_t e;
        e.a = a;
        e.w = w;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d entries still expected, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset(input logic sel);
        @(negedge clk);
        #1 resetn = 1'b0;
        dbg_we  = 1'b0;
        step    = 1'b0;
        freeze  = 1'b0;
        clr_ovf = 1'b0;
        #1 mon_sel = sel;
        q.delete();
        tick(2);
        resetn = 1'b1;
        tick(1);
    endtask

    // Called at a negedge; the new entry is loaded two edges later.
    task automatic step_exp(input logic [11:0] a, input logic [31:0] w, input logic visible);
        if (visible) push_exp(a, w, cyc + 2);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(3);
    endtask

    initial begin
        int k;
        n_cmp      = 0;
        n_err      = 0;
        resetn     = 1'b0;
        dbg_we     = 1'b0;
        debug_addr = '0;
        debug_word = '0;
        step       = 1'b0;
        freeze     = 1'b0;
        clr_ovf    = 1'b0;
        mon_sel    = 1'b0;

        // Reset values and a single write
        do_reset(1'b0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_addr",  64'(m_addr),  64'd0);
        chk("rst_word",  64'(m_word),  64'd0);
        chk("rst_count", 64'(m_count), 64'd0);
        chk("rst_ovf",   64'(m_ovf),   64'd0);
        chk("rst_drop",  64'(m_drop),  64'd0);
        k = cyc + 1;
        dbg_we = 1'b1; debug_addr = 12'h004; debug_word = 32'h0000_00AB;
        push_exp(12'h004, 32'h0000_00AB, k + 2);
        tick(1);
        dbg_we = 1'b0;
        chk("single_count_k", 64'(m_count), 64'd1);
        chk("single_valid_k", 64'(m_valid), 64'd0);
        tick(1);
        chk("single_valid_k1", 64'(m_valid), 64'd0);
        tick(1);
        chk("single_count_k2", 64'(m_count), 64'd0);
        drain(5);

        // Burst with auto-advance every 5 cycles on the fast instance
        do_reset(1'b1);
        k = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            dbg_we = 1'b1; debug_addr = 12'(i + 1); debug_word = 32'(i + 1);
            push_exp(12'(i + 1), 32'(i + 1), k + 2 + 5 * i);
            tick(1);
        end
        dbg_we = 1'b0;
        drain(30);
        tick(20);
        chk("burst_last_valid", 64'(m_valid), 64'd1);
        chk("burst_last_addr",  64'(m_addr),  64'h3);
        chk("burst_last_word",  64'(m_word),  64'h3);
        chk("burst_count",      64'(m_count), 64'd0);

        // Overflow, clear, saturation, clear-vs-drop, push into full with pop
        do_reset(1'b0);
        k = cyc + 1;
        for (int i = 0; i < 18; i++) begin
            dbg_we = 1'b1; debug_addr = 12'(12'h010 + i); debug_word = 32'(32'h100 + i);
            if (i == 0) push_exp(12'h010, 32'h100, k + 2);
            tick(1);
        end
        dbg_we = 1'b0;
        tick(2);
        chk("ovf_count", 64'(m_count), 64'd16);
        chk("ovf_flag",  64'(m_ovf),   64'd1);
        chk("ovf_drop",  64'(m_drop),  64'd1);
        drain(5);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("clr_flag",  64'(m_ovf),   64'd0);
        chk("clr_drop",  64'(m_drop),  64'd0);
        chk("clr_count", 64'(m_count), 64'd16);
        dbg_we = 1'b1; debug_addr = 12'h0EE; debug_word = 32'h0000_00EE;
        tick(300);
        dbg_we = 1'b0;
        chk("sat_drop", 64'(m_drop), 64'd255);
        chk("sat_flag", 64'(m_ovf),  64'd1);
        clr_ovf = 1'b1; dbg_we = 1'b1;
        tick(1);
        clr_ovf = 1'b0; dbg_we = 1'b0;
        chk("clrdrop_flag", 64'(m_ovf),  64'd1);
        chk("clrdrop_drop", 64'(m_drop), 64'd1);
        step = 1'b1;
        push_exp(12'h011, 32'h101, cyc + 2);
        tick(1);
        dbg_we = 1'b1; debug_addr = 12'h0AA; debug_word = 32'h0000_AAAA;
        tick(1);
        dbg_we = 1'b0; step = 1'b0;
        tick(1);
        chk("fullpop_count", 64'(m_count), 64'd16);
        chk("fullpop_drop",  64'(m_drop),  64'd1);
        drain(5);

        // Step and freeze
        do_reset(1'b0);
        k = cyc + 1;
        dbg_we = 1'b1; debug_addr = 12'h0C1; debug_word = 32'h0000_C001;
        push_exp(12'h0C1, 32'h0000_C001, k + 2);
        tick(1);
        debug_addr = 12'h0C2; debug_word = 32'h0000_C002;
        tick(1);
        debug_addr = 12'h0C3; debug_word = 32'h0000_C003;
        tick(1);
        dbg_we = 1'b0;
        tick(2);
        chk("step_queued", 64'(m_count), 64'd2);
        drain(5);
        step_exp(12'h0C2, 32'h0000_C002, 1'b1);
        chk("step_count", 64'(m_count), 64'd1);
        freeze = 1'b1;
        tick(1);
        step = 1'b1;
        tick(2000);
        chk("freeze_addr",  64'(m_addr),  64'h0C2);
        chk("freeze_word",  64'(m_word),  64'h0000_C002);
        chk("freeze_count", 64'(m_count), 64'd1);
        freeze = 1'b0;
        tick(1);
        step = 1'b0;
        tick(1);
        step_exp(12'h0C3, 32'h0000_C003, 1'b1);
        chk("step2_count", 64'(m_count), 64'd0);

        // Asynchronous reset with five entries queued
        do_reset(1'b0);
        k = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            dbg_we = 1'b1; debug_addr = 12'(12'h050 + i); debug_word = 32'(32'h5000 + i);
            if (i == 0) push_exp(12'h050, 32'h5000, k + 2);
            tick(1);
        end
        dbg_we = 1'b0;
        tick(1);
        chk("arst_pre_count", 64'(m_count), 64'd5);
        drain(5);
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", 64'(m_valid), 64'd0);
        chk("arst_addr",  64'(m_addr),  64'd0);
        chk("arst_word",  64'(m_word),  64'd0);
        chk("arst_count", 64'(m_count), 64'd0);
        tick(1);
        resetn = 1'b1;
        tick(2);
        chk("arst_post_count", 64'(m_count), 64'd0);
        chk("arst_post_valid", 64'(m_valid), 64'd0);

        // Writes A, A, B, A
        do_reset(1'b0);
        k = cyc + 1;
        push_exp(12'h0A0, 32'hA5A5_0001, k + 2);
        for (int i = 0; i < 4; i++) begin
            dbg_we = 1'b1;
            debug_addr = (i == 2) ? 12'h0B0 : 12'h0A0;
            debug_word = (i == 2) ? 32'hB5B5_0002 : 32'hA5A5_0001;
            tick(1);
        end
        dbg_we = 1'b0;
        tick(3);
        chk("dup_drop", 64'(m_drop), 64'd0);
        chk("dup_ovf",  64'(m_ovf),  64'd0);
        drain(5);
`ifdef DEBUG_TRACE_DEDUP_EN
        chk("dup_count", 64'(m_count), 64'd2);
`else
        chk("dup_count", 64'(m_count), 64'd3);
        step_exp(12'h0A0, 32'hA5A5_0001, 1'b0);
        chk("dup_count_a", 64'(m_count), 64'd2);
`endif
        step_exp(12'h0B0, 32'hB5B5_0002, 1'b1);
        step_exp(12'h0A0, 32'hA5A5_0001, 1'b1);
        chk("dup_final_count", 64'(m_count), 64'd0);
        drain(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
